// File: rtl/clk_gate_ctrl.sv
// clk_gate_ctrl: a clock-gating controller with NCH independent channels.
// Each channel turns its own clock off after a run of idle cycles and turns
// it back on when its unit becomes busy or asks for a wake-up. Each gated
// clock is a low-phase enable latch ANDed with clk, so it cannot glitch.
//
// Channel state machine:
//   state       | meaning
//   ------------+-------------------------------------------------------
//   ST_RUN      | clock running, channel active or gating not permitted
//   ST_IDLE_CNT | clock running, counting idle samples down to gating
//   ST_GATED    | clock stopped
//   ST_WAKE     | clock running again, waiting for it to settle before ack
//
// Ports:
//   clk          free-running source clock; all state updates on its rising edge
//   rst_n        asynchronous active-low reset
//   scan_enable  forces every clock enable high; the state machines keep running
//   auto_en      global permission to gate; 0 brings every channel back to RUN
//   busy         per-channel activity; 1 = the unit needs its clock
//   wake_req     per-channel wake request, held high until wake_ack
//   wake_ack     per-channel acknowledge (request high and channel in RUN)
//   gated        registered per-channel status, 1 = channel in GATED
//   gclk         per-channel gated clocks
module clk_gate_ctrl #(
  parameter int NCH         = 4,
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           scan_enable,
  input  logic           auto_en,
  input  logic [NCH-1:0] busy,
  input  logic [NCH-1:0] wake_req,
  output logic [NCH-1:0] wake_ack,
  output logic [NCH-1:0] gated,
  output logic [NCH-1:0] gclk
);

  localparam int CNT_MAX = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX) + 1;

  localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 1);
  localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_IDLE_CNT = 2'd1,
    ST_GATED    = 2'd2,
    ST_WAKE     = 2'd3
  } state_t;

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          gated_q;
    logic          act;
    logic          en_req;
    logic          en_lat;

    assign act = busy[g] | wake_req[g];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state   <= ST_RUN;
        cnt     <= '0;
        gated_q <= 1'b0;
      end else begin
        state   <= state_nxt;
        cnt     <= cnt_nxt;
        gated_q <= (state_nxt == ST_GATED);
      end
    end

    always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      unique case (state)
        ST_RUN: begin
          if (!act && auto_en) begin
            state_nxt = ST_IDLE_CNT;
            cnt_nxt   = IDLE_LOAD;
          end
        end
        ST_IDLE_CNT: begin
          // activity or loss of permission wins over an expiring count
          if (act || !auto_en) begin
            state_nxt = ST_RUN;
          end else if (cnt == '0) begin
            state_nxt = ST_GATED;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        ST_GATED: begin
          if (act || !auto_en) begin
            state_nxt = ST_WAKE;
            cnt_nxt   = WAKE_LOAD;
          end
        end
        ST_WAKE: begin
          // inputs are ignored here: a started wake always runs to completion
          if (cnt == '0) begin
            state_nxt = ST_RUN;
          end else begin
            cnt_nxt = cnt - CNT_ONE;
          end
        end
        default: begin
          state_nxt = ST_RUN;
          cnt_nxt   = '0;
        end
      endcase
    end

    assign en_req = (state != ST_GATED) | scan_enable;

    // The enable only moves while clk is low, so the AND below can neither
    // chop a high pulse nor start one mid-phase. Reset forces the latch open
    // so the clock runs from the moment reset is asserted.
    always_latch begin
      if (!rst_n) begin
        en_lat <= 1'b1;
      end else if (!clk) begin
        en_lat <= en_req;
      end
    end

    assign gclk[g]     = clk & en_lat;
    assign gated[g]    = gated_q;
    assign wake_ack[g] = wake_req[g] & (state == ST_RUN) & rst_n;
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl. Directed scenarios (reset, idle
// gating latency, wake handshake, interrupted count, overrides, reset during
// a wake) are followed by a randomized phase. Each channel is modelled by an
// idle-streak count, a remaining-wake count and a gated flag.
module tb_clk_gate_ctrl;
  localparam int NCH         = 4;
  localparam int IDLE_CYCLES = 16;
  localparam int WAKE_CYCLES = 2;

  logic           clk         = 1'b0;
  logic           rst_n       = 1'b0;
  logic           scan_enable = 1'b0;
  logic           auto_en     = 1'b1;
  logic [NCH-1:0] busy        = '0;
  logic [NCH-1:0] wake_req    = '0;
  logic [NCH-1:0] wake_ack;
  logic [NCH-1:0] gated;
  logic [NCH-1:0] gclk;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: consecutive idle samples seen while running, edges of
  // wake left to go, and whether the clock is off
  int m_streak [NCH];
  int m_wake   [NCH];
  bit m_gated  [NCH];

  logic [NCH-1:0] ack_seen = '0;

  clk_gate_ctrl #(
    .NCH        (NCH),
    .IDLE_CYCLES(IDLE_CYCLES),
    .WAKE_CYCLES(WAKE_CYCLES)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_enable(scan_enable),
    .auto_en    (auto_en),
    .busy       (busy),
    .wake_req   (wake_req),
    .wake_ack   (wake_ack),
    .gated      (gated),
    .gclk       (gclk)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at time %0t", tag, got, exp, $time);
    end
  endtask

  // gclk may only rise while clk is high and only fall while clk is low
  for (genvar g = 0; g < NCH; g++) begin : g_mon
    always @(posedge gclk[g]) chk("gclk_rise_phase", {31'd0, clk}, 32'd1);
    always @(negedge gclk[g]) chk("gclk_fall_phase", {31'd0, clk}, 32'd0);
  end

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_streak[i] = 0;
      m_wake[i]   = 0;
      m_gated[i]  = 1'b0;
    end
  endfunction

  function automatic logic [NCH-1:0] exp_run();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++)
      v[i] = !m_gated[i] && (m_wake[i] == 0) && (m_streak[i] == 0);
    return v;
  endfunction

  function automatic logic [NCH-1:0] exp_gated();
    logic [NCH-1:0] v;
    for (int i = 0; i < NCH; i++) v[i] = m_gated[i];
    return v;
  endfunction

  function automatic void model_edge(input logic [NCH-1:0] b, input logic [NCH-1:0] r,
                                     input logic a);
    for (int i = 0; i < NCH; i++) begin
      bit act;
      act = b[i] | r[i];
      if (m_wake[i] > 0) begin
        m_wake[i]--;
      end else if (m_gated[i]) begin
        if (act || !a) begin
          m_gated[i] = 1'b0;
          m_wake[i]  = WAKE_CYCLES;
        end
      end else if (!act && a) begin
        // gating needs the first idle sample plus IDLE_CYCLES more
        m_streak[i]++;
        if (m_streak[i] == IDLE_CYCLES + 1) begin
          m_gated[i]  = 1'b1;
          m_streak[i] = 0;
        end
      end else begin
        m_streak[i] = 0;
      end
    end
  endfunction

  // one clock cycle: drive in the low phase, check ack there, then check the
  // high phase of gclk and the registered status after the edge
  task automatic step(input logic [NCH-1:0] b, input logic [NCH-1:0] r,
                      input logic a, input logic s);
    logic [NCH-1:0] en_e;
    logic [NCH-1:0] ack_e;
    @(negedge clk);
    busy        = b;
    wake_req    = r;
    auto_en     = a;
    scan_enable = s;
    #1;
    ack_seen = wake_ack;
    ack_e    = rst_n ? (r & exp_run()) : '0;
    chk("wake_ack", {28'd0, wake_ack}, {28'd0, ack_e});
    en_e = '1;
    if (rst_n) en_e = ~exp_gated() | {NCH{s}};
    @(posedge clk);
    #1;
    chk("gclk_high", {28'd0, gclk}, {28'd0, en_e});
    if (rst_n) model_edge(b, r, a);
    chk("gated", {28'd0, gated}, {28'd0, exp_gated()});
  endtask

  // counts edges from the first idle sample until gated[ch] is set
  task automatic measure_gate(input int ch, input logic [NCH-1:0] b);
    int cnt;
    cnt = 0;
    while (cnt < 3 * IDLE_CYCLES) begin
      step(b, '0, 1'b1, 1'b0);
      cnt++;
      if (gated[ch]) break;
    end
    chk("gate_latency", cnt, IDLE_CYCLES + 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [NCH-1:0] b;
    logic [NCH-1:0] r;
    logic           a;
    logic           s;
    int             cnt;

    model_reset();

    // reset held: clocks run, no status, requests never acknowledged
    repeat (3) step('0, '1, 1'b1, 1'b0);
    #2 rst_n = 1'b1;

    // every channel gates after the first idle sample plus IDLE_CYCLES edges
    measure_gate(0, '0);
    chk("all_gated_after_reset", {28'd0, gated}, {28'd0, {NCH{1'b1}}});

    // only channel 0 goes idle; the others stay running
    repeat (WAKE_CYCLES + 2) step('1, '0, 1'b1, 1'b0);
    b    = '1;
    b[0] = 1'b0;
    measure_gate(0, b);
    chk("others_running", {28'd0, gated}, 32'd1);

    // wake handshake on channel 1
    repeat (IDLE_CYCLES + 2) step('0, '0, 1'b1, 1'b0);
    r    = '0;
    r[1] = 1'b1;
    step('0, r, 1'b1, 1'b0);
    cnt = 0;
    while (cnt < 20) begin
      step('0, r, 1'b1, 1'b0);
      if (ack_seen[1]) break;
      cnt++;
    end
    chk("wake_latency", cnt, WAKE_CYCLES);
    measure_gate(1, '0);

    // channel 2: one busy sample restarts the idle count
    repeat (WAKE_CYCLES + 2) step('1, '0, 1'b1, 1'b0);
    b    = '1;
    b[2] = 1'b0;
    repeat (IDLE_CYCLES - 1) step(b, '0, 1'b1, 1'b0);
    step('1, '0, 1'b1, 1'b0);
    chk("no_early_gate", {31'd0, gated[2]}, 32'd0);
    measure_gate(2, b);

    // scan override: clocks run while status stays gated
    repeat (IDLE_CYCLES + 2) step('0, '0, 1'b1, 1'b0);
    step('0, '0, 1'b1, 1'b1);
    chk("scan_gclk", {28'd0, gclk}, {28'd0, {NCH{1'b1}}});
    chk("scan_gated", {28'd0, gated}, {28'd0, {NCH{1'b1}}});
    step('0, '0, 1'b1, 1'b0);

    // dropping auto_en returns every channel to RUN within WAKE_CYCLES+1 edges
    repeat (WAKE_CYCLES + 1) step('0, '0, 1'b0, 1'b0);
    step('0, '1, 1'b0, 1'b0);
    chk("auto_off_ack", {28'd0, ack_seen}, {28'd0, {NCH{1'b1}}});
    step('0, '0, 1'b0, 1'b0);

    // asynchronous reset in the middle of a wake
    repeat (IDLE_CYCLES + 2) step('0, '0, 1'b1, 1'b0);
    step('1, '0, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    wake_req = '1;
    rst_n    = 1'b0;
    model_reset();
    #1;
    chk("rst_gated", {28'd0, gated}, 32'd0);
    chk("rst_ack", {28'd0, wake_ack}, 32'd0);
    repeat (2) step('1, '1, 1'b1, 1'b0);
    #2 rst_n = 1'b1;
    step('0, '1, 1'b1, 1'b0);
    chk("ack_after_reset", {28'd0, ack_seen}, {28'd0, {NCH{1'b1}}});
    step('0, '0, 1'b1, 1'b0);

    // randomized traffic with a requester that holds wake_req until acked
    r = '0;
    a = 1'b1;
    s = 1'b0;
    repeat (1500) begin
      for (int i = 0; i < NCH; i++) begin
        b[i] = ($urandom_range(0, 29) == 0);
        if (r[i] && ack_seen[i]) r[i] = 1'b0;
        else if (!r[i] && ($urandom_range(0, 49) == 0)) r[i] = 1'b1;
      end
      if ($urandom_range(0, 99) == 0) a = ~a;
      if ($urandom_range(0, 199) == 0) s = ~s;
      step(b, r, a, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
